// File: rtl/restoring_divider_pkg.sv
// Shared types and defaults for the restoring divider.
// Holds the FSM state encoding, the default operand width and a counter-width helper.
package restoring_divider_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoadQ,
        StLoadM,
        StIter,
        StDone
    } div_state_e;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/restoring_divider_ctrl.sv
// Sequencing FSM for the restoring divider.
// Drives load, iterate and result-latch strobes into the datapath.
module restoring_divider_ctrl
    import restoring_divider_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic divisor_zero_i,
    input  logic count_last_i,
    output logic load_q_o,
    output logic load_m_o,
    output logic iter_o,
    output logic latch_o,
    output logic zero_o,
    output logic busy_o,
    output logic done_o
);

    div_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StLoadQ;
            StLoadQ: state_d = StLoadM;
            StLoadM: state_d = divisor_zero_i ? StDone : StIter;
            StIter:  if (count_last_i) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Results are latched on the edge that enters StDone, from either path.
    always_comb begin
        load_q_o = 1'b0;
        load_m_o = 1'b0;
        iter_o   = 1'b0;
        latch_o  = 1'b0;
        zero_o   = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        unique case (state_q)
            StLoadQ: begin
                load_q_o = 1'b1;
                busy_o   = 1'b1;
            end
            StLoadM: begin
                load_m_o = 1'b1;
                busy_o   = 1'b1;
                latch_o  = divisor_zero_i;
                zero_o   = divisor_zero_i;
            end
            StIter: begin
                iter_o  = 1'b1;
                busy_o  = 1'b1;
                latch_o = count_last_i;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/restoring_divider.sv
// Unsigned multi-cycle restoring divider: one quotient bit per clock.
// Operands arrive serially on data_in (dividend, then divisor).
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    logic             load_q, load_m, iter, latch, zero;
    logic             divisor_zero, count_last;
    logic [WIDTH:0]   a_q, a_d, a_shift, a_diff, a_step;
    logic [WIDTH-1:0] q_q, q_d, q_step, m_q, m_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    assign divisor_zero = (data_in == '0);
    assign count_last   = (cnt_q == CntW'(1));

    restoring_divider_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .divisor_zero_i (divisor_zero),
        .count_last_i   (count_last),
        .load_q_o       (load_q),
        .load_m_o       (load_m),
        .iter_o         (iter),
        .latch_o        (latch),
        .zero_o         (zero),
        .busy_o         (busy),
        .done_o         (done)
    );

    // One restoring step: shift {A,Q}, trial-subtract M, keep or restore.
    always_comb begin
        a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        a_diff  = a_shift - {1'b0, m_q};
        a_step  = a_diff[WIDTH] ? a_shift : a_diff;
        q_step  = {q_q[WIDTH-2:0], ~a_diff[WIDTH]};
    end

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (load_q) begin
            q_d   = data_in;
            dbz_d = 1'b0;
        end
        if (load_m) begin
            m_d   = data_in;
            a_d   = '0;
            cnt_d = CntW'(WIDTH);
        end
        if (iter) begin
            a_d   = a_step;
            q_d   = q_step;
            cnt_d = cnt_q - CntW'(1);
        end
        if (latch) begin
            if (zero) begin
                quot_d = '1;
                rem_d  = q_q;
                dbz_d  = 1'b1;
            end else begin
                quot_d = q_step;
                rem_d  = a_step[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            q_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: scoreboard of expected results
// pushed when operands are driven and popped when done fires.
module tb_restoring_divider;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the FSM idle; returns at the idle negedge after done.
    task automatic do_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input bit keep);
        exp_t e;
        int   e0;
        bit   busy_ok;
        bit   seen;
        e.q   = (dvs == 0) ? {W{1'b1}} : dvd / dvs;
        e.r   = (dvs == 0) ? dvd : dvd % dvs;
        e.dz  = (dvs == 0);
        e.lat = (dvs == 0) ? 2 : W + 2;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        sb.push_back(e);
        busy_ok = (busy === 1'b1);
        start   = keep;
        data_in = dvd;
        @(negedge clk);
        busy_ok = busy_ok && (busy === 1'b1);
        data_in = dvs;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else busy_ok = busy_ok && (busy === 1'b1);
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        e = sb.pop_front();
        if (seen) begin
            check_eq("latency", 32'(cyc - e0), 32'(e.lat));
            check_eq("quotient", 32'(quotient), 32'(e.q));
            check_eq("remainder", 32'(remainder), 32'(e.r));
            check_eq("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            check_eq("busy_in_op", 32'(busy_ok), 32'd1);
            check_eq("busy_at_done", 32'(busy), 32'd0);
            @(negedge clk);
            check_eq("done_pulse", 32'(done), 32'd0);
            check_eq("quotient_hold", 32'(quotient), 32'(e.q));
            check_eq("remainder_hold", 32'(remainder), 32'(e.r));
        end
    endtask

    initial begin
        bit seen_done;
        repeat (2) @(negedge clk);
        check_eq("rst_quotient", 32'(quotient), 32'd0);
        check_eq("rst_remainder", 32'(remainder), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_div(16'd100, 16'd7, 1'b0);
        do_div(16'd3, 16'd7, 1'b0);
        do_div(16'hFFFF, 16'd1, 1'b0);
        do_div(16'hFFFF, 16'hFFFF, 1'b0);
        do_div(16'd5, 16'd0, 1'b0);
        do_div(16'd0, 16'd9, 1'b0);

        // Abandon a 100/7 operation mid-iteration with an async reset.
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd100;
        @(negedge clk);
        data_in = 16'd7;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_quotient", 32'(quotient), 32'd0);
        check_eq("midrst_remainder", 32'(remainder), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check_eq("no_done_after_rst", 32'(seen_done), 32'd0);
        do_div(16'd100, 16'd7, 1'b0);

        // start held high: second operation starts on the first idle edge.
        do_div(16'd1000, 16'd33, 1'b1);
        do_div(16'd50000, 16'd123, 1'b0);

        for (int k = 0; k < 4; k++) begin
            do_div(16'($urandom_range(0, 65535)), 16'($urandom_range(1, 65535)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
